// File: rtl/modulator_pkg.sv
// Constants shared by the PWM modulator frequency controller and the board wrapper.
// Divide factors and debounce counts assume a 100 MHz core clock.
package modulator_pkg;

    localparam int unsigned FCLK_HZ             = 100_000_000;
    localparam logic [31:0] DIV_FACTOR_FREQLOW  = 32'd389120;
    localparam logic [31:0] DIV_FACTOR_FREQHIGH = 32'd110592;
    // 10 ms of stable switch level before a change is believed
    localparam logic [19:0] DEBOUNCE_CNT        = 20'(FCLK_HZ / 100);
    localparam logic [7:0]  SWEEP_PERIODS       = 8'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        APPLY = 2'd2
    } state_e;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser followed by a saturating debounce counter.
// sync_o lags the pad by 2 cycles; stable_o follows after COUNT stable cycles.
module switch_debouncer
    import modulator_pkg::*;
#(
    parameter int unsigned             WIDTH = 20,
    parameter logic [WIDTH-1:0]        COUNT = WIDTH'(DEBOUNCE_CNT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic sync_o,
    output logic stable_o
);

    logic [1:0]       sync_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    assign sync_o   = sync_q[1];
    assign stable_o = stable_q;

    // The >= compare doubles as saturation: the counter can never pass COUNT-1.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_o == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= COUNT - WIDTH'(1)) begin
            stable_d = sync_o;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], sw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/modulator_freq_ctrl.sv
// Selects the modulator divide factor from a debounced switch or an automatic sweep.
// New factor lands 2 cycles after the period_end that follows a change request.
module modulator_freq_ctrl
    import modulator_pkg::*;
#(
    parameter int unsigned               div_width_p          = 32,
    parameter logic [div_width_p-1:0]    div_factor_freqlow_p  = div_width_p'(DIV_FACTOR_FREQLOW),
    parameter logic [div_width_p-1:0]    div_factor_freqhigh_p = div_width_p'(DIV_FACTOR_FREQHIGH),
    parameter int unsigned               dbc_width_p          = 20,
    parameter logic [dbc_width_p-1:0]    debounce_cnt_p       = dbc_width_p'(DEBOUNCE_CNT),
    parameter logic [7:0]                sweep_periods_p      = SWEEP_PERIODS
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   sw0,
    input  logic                   sweep_en,
    input  logic                   period_end,
    output logic [div_width_p-1:0] div_factor_o,
    output logic                   freq_sel_o,
    output logic                   change_pending_o,
    output logic                   update_o
);

    logic sw_stable, sweep_s, target;

    state_e                 state_q, state_d;
    logic [7:0]             sweep_cnt_q, sweep_cnt_d;
    logic                   sweep_tgt_q, sweep_tgt_d;
    logic                   freq_sel_q, freq_sel_d;
    logic [div_width_p-1:0] div_q, div_d;
    logic                   pend_q, upd_q;

    switch_debouncer #(.WIDTH(dbc_width_p), .COUNT(debounce_cnt_p)) u_sw_dbc (
        .clk_i    (clk_in),
        .rst_i    (rst),
        .sw_i     (sw0),
        .sync_o   (),
        .stable_o (sw_stable)
    );

    // Sweep enable is a mode switch, so synchronising it is enough.
    switch_debouncer #(.WIDTH(dbc_width_p), .COUNT(debounce_cnt_p)) u_sweep_dbc (
        .clk_i    (clk_in),
        .rst_i    (rst),
        .sw_i     (sweep_en),
        .sync_o   (sweep_s),
        .stable_o ()
    );

    assign target = sweep_s ? sweep_tgt_q : sw_stable;

    always_comb begin
        sweep_cnt_d = sweep_cnt_q;
        sweep_tgt_d = sweep_tgt_q;
        if (!sweep_s) begin
            sweep_cnt_d = '0;
            sweep_tgt_d = freq_sel_q;
        end else if (period_end) begin
            if (sweep_cnt_q + 8'd1 >= sweep_periods_p) begin
                sweep_cnt_d = '0;
                sweep_tgt_d = ~sweep_tgt_q;
            end else begin
                sweep_cnt_d = sweep_cnt_q + 8'd1;
            end
        end
    end

    // A period_end coincident with RUN->WAIT is ignored; WAIT only leaves on a later pulse.
    always_comb begin
        state_d    = state_q;
        freq_sel_d = freq_sel_q;
        div_d      = div_q;
        unique case (state_q)
            RUN: begin
                if (target != freq_sel_q) state_d = WAIT;
            end
            WAIT: begin
                if (target == freq_sel_q) state_d = RUN;
                else if (period_end)      state_d = APPLY;
            end
            APPLY: begin
                state_d    = RUN;
                freq_sel_d = target;
                div_d      = target ? div_factor_freqhigh_p : div_factor_freqlow_p;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            sweep_cnt_q <= '0;
            sweep_tgt_q <= 1'b0;
            freq_sel_q  <= 1'b0;
            div_q       <= div_factor_freqlow_p;
            pend_q      <= 1'b0;
            upd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            sweep_tgt_q <= sweep_tgt_d;
            freq_sel_q  <= freq_sel_d;
            div_q       <= div_d;
            pend_q      <= (state_d == WAIT);
            upd_q       <= (state_q == APPLY);
        end
    end

    assign div_factor_o     = div_q;
    assign freq_sel_o       = freq_sel_q;
    assign change_pending_o = pend_q;
    assign update_o         = upd_q;

endmodule

// File: tb/tb_modulator_freq_ctrl.sv
// Bench for modulator_freq_ctrl: vector table for debounce behaviour plus
// hand sequences; every update_o pulse is matched against a scoreboard queue.
module tb_modulator_freq_ctrl;

    localparam logic [31:0] LOW  = 32'd389120;
    localparam logic [31:0] HIGH = 32'd110592;

    logic        clk, rst, sw0, sweep_en, period_end;
    logic [31:0] div_factor_o;
    logic        freq_sel_o, change_pending_o, update_o;

    int checks = 0;
    int errors = 0;

    int pe_count   = 0;
    int req_cnt    = 0;
    int served_cnt = 0;
    int pe_timer   = 0;
    bit pe_en      = 0;

    typedef struct {
        logic [31:0] div;
        logic        sel;
        int          pe_idx;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    typedef struct {
        logic        sw;
        int          hold;
        logic        exp_pend;
        logic [31:0] exp_div;
    } vec_t;
    vec_t vecs[22];

    modulator_freq_ctrl #(
        .div_width_p          (32),
        .div_factor_freqlow_p (32'd389120),
        .div_factor_freqhigh_p(32'd110592),
        .dbc_width_p          (20),
        .debounce_cnt_p       (20'd16),
        .sweep_periods_p      (8'd4)
    ) dut (
        .clk_in          (clk),
        .rst             (rst),
        .sw0             (sw0),
        .sweep_en        (sweep_en),
        .period_end      (period_end),
        .div_factor_o    (div_factor_o),
        .freq_sel_o      (freq_sel_o),
        .change_pending_o(change_pending_o),
        .update_o        (update_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    // period_end source: periodic when pe_en, plus one-shot pulses on request
    initial begin
        period_end = 0;
        forever begin
            @(posedge clk);
            #1;
            if ((pe_en && pe_timer == 99) || req_cnt != served_cnt) begin
                period_end = 1;
                pe_timer   = 0;
                pe_count++;
                if (req_cnt != served_cnt) served_cnt++;
            end else begin
                period_end = 0;
                pe_timer   = pe_en ? pe_timer + 1 : 0;
            end
        end
    end

    logic pe_prev = 0;
    always @(posedge clk) begin
        if (!rst) assert (!(period_end && pe_prev)) else $error("period_end held high for more than one cycle");
        pe_prev <= period_end;
    end

    logic        rst_prev = 1;
    logic [31:0] div_prev = 0;
    always @(negedge clk) begin
        if (!rst && !rst_prev) begin
            if (update_o) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: got div %0d sel %0d, expected no update", div_factor_o, freq_sel_o);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (div_factor_o !== mon_e.div || freq_sel_o !== mon_e.sel || pe_count != mon_e.pe_idx) begin
                        errors++;
                        $display("FAIL update: got div %0d sel %0d after pulse %0d, expected div %0d sel %0d after pulse %0d",
                                 div_factor_o, freq_sel_o, pe_count, mon_e.div, mon_e.sel, mon_e.pe_idx);
                    end
                end
            end else if (div_factor_o !== div_prev) begin
                checks++;
                errors++;
                $display("FAIL silent_div_change: got %0d without update_o, expected %0d", div_factor_o, div_prev);
            end
        end
        rst_prev = rst;
        div_prev = div_factor_o;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_req();
        req_cnt++;
    endtask

    initial begin
        int   base;
        int   n;
        logic any;
        logic obs;

        // 10 bounces of 10 cycles high / 10 low, then a held edge
        for (int i = 0; i < 20; i++) begin
            vecs[i] = '{sw: (i % 2 == 0), hold: 10, exp_pend: 1'b0, exp_div: LOW};
        end
        vecs[20] = '{sw: 1'b1, hold: 18, exp_pend: 1'b0, exp_div: LOW};
        vecs[21] = '{sw: 1'b1, hold: 1,  exp_pend: 1'b1, exp_div: LOW};

        rst = 1; sw0 = 0; sweep_en = 0;
        repeat (3) tick();
        chk("reset_div",     div_factor_o,     LOW);
        chk("reset_sel",     freq_sel_o,       0);
        chk("reset_pending", change_pending_o, 0);
        chk("reset_update",  update_o,         0);
        rst = 0;

        for (int i = 0; i < 22; i++) begin
            sw0 = vecs[i].sw;
            any = 0;
            repeat (vecs[i].hold) begin
                tick();
                any |= change_pending_o;
            end
            obs = vecs[i].exp_pend ? change_pending_o : any;
            chk($sformatf("vec%0d_pending", i), obs, vecs[i].exp_pend);
            chk($sformatf("vec%0d_div", i), div_factor_o, vecs[i].exp_div);
        end

        // accepted change applied at the next period_end
        sb_q.push_back('{div: HIGH, sel: 1'b1, pe_idx: pe_count + 1});
        pulse_req();
        tick();
        tick();
        chk("apply_cycle_div",     div_factor_o,     LOW);
        chk("apply_cycle_pending", change_pending_o, 0);
        tick();
        chk("applied_div",    div_factor_o, HIGH);
        chk("applied_sel",    freq_sel_o,   1);
        chk("applied_update", update_o,     1);
        tick();
        chk("update_one_cycle", update_o, 0);

        // revert while pending: no update at the following period_end
        sw0 = 0;
        repeat (19) tick();
        chk("revert_pending_up", change_pending_o, 1);
        sw0 = 1;
        repeat (19) tick();
        chk("revert_pending_down", change_pending_o, 0);
        pulse_req();
        repeat (5) tick();
        chk("revert_div", div_factor_o, HIGH);
        chk("revert_sel", freq_sel_o,   1);

        sw0 = 0;
        repeat (19) tick();
        sb_q.push_back('{div: LOW, sel: 1'b0, pe_idx: pe_count + 1});
        pulse_req();
        repeat (4) tick();
        chk("back_low_div", div_factor_o, LOW);

        // sweep: toggles land at pulses 5, 9, 13; dropping sweep returns to sw0 at 14
        sweep_en = 1;
        repeat (4) tick();
        base = pe_count;
        sb_q.push_back('{div: HIGH, sel: 1'b1, pe_idx: base + 5});
        sb_q.push_back('{div: LOW,  sel: 1'b0, pe_idx: base + 9});
        sb_q.push_back('{div: HIGH, sel: 1'b1, pe_idx: base + 13});
        pe_en = 1;
        n = 0;
        while (pe_count < base + 13 && n < 2000) begin
            tick();
            n++;
        end
        chk("sweep_reached_pulse13", 32'(pe_count >= base + 13), 1);
        repeat (3) tick();
        chk("sweep_div_after13", div_factor_o, HIGH);
        sweep_en = 0;
        sb_q.push_back('{div: LOW, sel: 1'b0, pe_idx: base + 14});
        n = 0;
        while (pe_count < base + 14 && n < 300) begin
            tick();
            n++;
        end
        chk("sweep_reached_pulse14", 32'(pe_count >= base + 14), 1);
        repeat (3) tick();
        chk("sweep_off_div", div_factor_o, LOW);
        chk("sweep_off_sel", freq_sel_o,   0);
        pe_en = 0;
        tick();

        // reset while waiting for period_end
        sw0 = 1;
        repeat (19) tick();
        chk("rst_wait_pending_before", change_pending_o, 1);
        rst = 1;
        #1;
        chk("rst_wait_pending", change_pending_o, 0);
        chk("rst_wait_div",     div_factor_o,     LOW);
        chk("rst_wait_sel",     freq_sel_o,       0);
        chk("rst_wait_update",  update_o,         0);
        sw0 = 0;
        tick();
        tick();
        rst = 0;
        pulse_req();
        repeat (5) tick();
        chk("post_rst_pending", change_pending_o, 0);
        chk("post_rst_div",     div_factor_o,     LOW);

        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
